dk8e_clock: RTL and testbench

DK8E_CLOCK -- requirements
Module: dk8e_clock

---
 rtl/dk8e_clock.sv | 150 +++++++++++++++
 tb/tb_dk8e_clock.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dk8e_clock.sv
// dk8e_clock: DK8-E real-time clock (IOT device 13) with a 21-bit rate prescaler.
// Build option DK8E_PRESET_EN adds the CLPR preset register; without it, overflow reloads 0000.
module dk8e_clock #(
    parameter logic [4:0] F3 = 5'd3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic [0:11] instruction,
    input  logic [4:0]  state,
    input  logic [0:11] ac,
    input  logic        UF,
    output logic [0:11] clk_bus,
    output logic        interrupt,
    output logic        skip
);

    localparam logic [8:0] IOT_DEV = 9'o613;

    logic        r_int_ena;
    logic        r_flag;
    logic [2:0]  r_rate;
    logic [11:0] r_count;
    logic [20:0] r_prescale;

    logic        w_iot;
    logic [2:0]  w_fn;
    logic        w_clie;
    logic        w_clid;
    logic        w_clsk;
    logic        w_cllr;
    logic        w_clrd;
    logic        w_clcl;
    logic [20:0] w_term;
    logic        w_tick;
    logic        w_ovf;
    logic [11:0] w_reload;
    logic        w_unused;

    // User mode traps IOTs, so UF=1 suppresses every side effect of the decode.
    assign w_iot  = (instruction[0:8] == IOT_DEV) && (state == F3) && !UF;
    assign w_fn   = instruction[9:11];
    assign w_clie = w_iot && (w_fn == 3'd1);
    assign w_clid = w_iot && (w_fn == 3'd2);
    assign w_clsk = w_iot && (w_fn == 3'd3);
    assign w_cllr = w_iot && (w_fn == 3'd4);
    assign w_clrd = w_iot && (w_fn == 3'd5);
    assign w_clcl = w_iot && (w_fn == 3'd7);

    // Terminal count is period-1; rate 7 terminates at 0, i.e. a tick on every clock.
    always_comb begin
        w_term = 21'd0;
        case (r_rate)
            3'd1:    w_term = 21'd999;
            3'd2:    w_term = 21'd9999;
            3'd3:    w_term = 21'd99999;
            3'd4:    w_term = 21'd999999;
            3'd5:    w_term = 21'd1666666;
            3'd6:    w_term = 21'd1999999;
            default: w_term = 21'd0;
        endcase
    end

    assign w_tick = (r_rate != 3'd0) && (r_prescale == w_term);
    assign w_ovf  = w_tick && (r_count == 12'o7777);

`ifdef DK8E_PRESET_EN
    logic        w_clpr;
    logic [11:0] r_preset;

    assign w_clpr   = w_iot && (w_fn == 3'd6);
    assign w_reload = r_preset;
    assign w_unused = 1'b0;

    // Preset survives the front-panel CLEAR; only the power-on reset zeroes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_preset <= 12'o0000;
        end else if (w_clpr) begin
            r_preset <= ac;
        end
    end
`else
    assign w_reload = 12'o0000;
    assign w_unused = &{1'b0, ac[0:8]};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prescale <= 21'd0;
        end else if (clear || w_cllr || w_clcl || w_tick || (r_rate == 3'd0)) begin
            r_prescale <= 21'd0;
        end else begin
            r_prescale <= r_prescale + 21'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rate <= 3'd0;
        end else if (clear) begin
            r_rate <= 3'd0;
        end else if (w_cllr) begin
            r_rate <= ac[9:11];
        end
    end

    // CLCL beats a coincident tick, so the count always ends at 0000 after CLCL.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= 12'o0000;
        end else if (clear || w_clcl) begin
            r_count <= 12'o0000;
        end else if (w_ovf) begin
            r_count <= w_reload;
        end else if (w_tick) begin
            r_count <= r_count + 12'd1;
        end
    end

    // An overflow landing on a CLSK/CLCL cycle must not be lost: set wins over clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_flag <= 1'b0;
        end else if (clear) begin
            r_flag <= 1'b0;
        end else if (w_ovf) begin
            r_flag <= 1'b1;
        end else if (w_clsk || w_clcl) begin
            r_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_int_ena <= 1'b0;
        end else if (clear) begin
            r_int_ena <= 1'b0;
        end else if (w_clie) begin
            r_int_ena <= 1'b1;
        end else if (w_clid) begin
            r_int_ena <= 1'b0;
        end
    end

    assign clk_bus   = w_clrd ? r_count : 12'o0000;
    assign skip      = w_clsk && r_flag;
    assign interrupt = r_flag && r_int_ena;

endmodule

// File: tb/tb_dk8e_clock.sv
// tb_dk8e_clock: scoreboard bench for dk8e_clock; expectations adapt to DK8E_PRESET_EN.
module tb_dk8e_clock;

    localparam logic [4:0] F3   = 5'd3;
    localparam logic [4:0] IDLE = 5'd0;
`ifdef DK8E_PRESET_EN
    localparam logic [11:0] PRE     = 12'o7770;
    localparam logic        HAS_PRE = 1'b1;
`else
    localparam logic [11:0] PRE     = 12'o0000;
    localparam logic        HAS_PRE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        clear = 1'b0;
    logic        UF = 1'b0;
    logic [0:11] instruction = 12'o0000;
    logic [0:11] ac = 12'o0000;
    logic [4:0]  state = IDLE;
    logic [0:11] clk_bus;
    logic        interrupt;
    logic        skip;

    typedef struct packed {
        logic [11:0] bus;
        logic        skp;
        logic        intr;
    } obs_t;

    obs_t  exp_q[$];
    obs_t  obs_q[$];
    string nm_q[$];
    obs_t  e;
    obs_t  o;
    string nm;
    int    n_err = 0;
    int    n_chk = 0;

    dk8e_clock #(.F3(F3)) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .instruction(instruction),
        .state(state), .ac(ac), .UF(UF), .clk_bus(clk_bus),
        .interrupt(interrupt), .skip(skip)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name, input logic [11:0] bus, input logic s, input logic i);
        obs_t x;
        x = {bus, s, i};
        exp_q.push_back(x);
        nm_q.push_back(name);
    endtask

    task automatic capture();
        obs_t x;
        x = {clk_bus, skip, interrupt};
        obs_q.push_back(x);
    endtask

    // One IOT 613x cycle in F3; outputs captured mid-cycle, cycle ends at the next rising edge.
    task automatic iot(input logic [2:0] fn, input logic [11:0] acv);
        instruction = {9'o613, fn};
        state = F3;
        ac = acv;
        @(negedge clk);
        capture();
        step();
        instruction = 12'o0000;
        state = IDLE;
        ac = 12'o0000;
    endtask

    task automatic look();
        @(negedge clk);
        capture();
        step();
    endtask

    task automatic run_to_overflow_and_stop(input string name);
        push_exp({name, "_cllr7"}, 12'o0000, 1'b0, interrupt);
        iot(3'd4, 12'o0007);
        repeat (4095) step();
        push_exp({name, "_stop"}, 12'o0000, 1'b0, interrupt);
        iot(3'd4, 12'o0000);
    endtask

    task automatic test_reset();
        #22 resetn = 1'b1;
        step();
        push_exp("rst_idle", 12'o0000, 1'b0, 1'b0);  look();
        push_exp("rst_clrd", 12'o0000, 1'b0, 1'b0);  iot(3'd5, 12'o0000);
        push_exp("rst_clsk", 12'o0000, 1'b0, 1'b0);  iot(3'd3, 12'o0000);
        push_exp("rst_6130", 12'o0000, 1'b0, 1'b0);  iot(3'd0, 12'o7777);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = nm_q.pop_front(); n_chk++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no observation, need bus=%o", nm, e.bus); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL %s: got bus=%o skip=%b int=%b, need bus=%o skip=%b int=%b", nm, o.bus, o.skp, o.intr, e.bus, e.skp, e.intr); end
            end
        end
    endtask

    task automatic test_overflow();
        push_exp("cllr7", 12'o0000, 1'b0, 1'b0);         iot(3'd4, 12'o0007);
        repeat (4095) step();
        push_exp("cnt_7777", 12'o7777, 1'b0, 1'b0);      iot(3'd5, 12'o0000);
        push_exp("cnt_wrap", 12'o0000, 1'b0, 1'b0);      iot(3'd5, 12'o0000);
        push_exp("clsk_flag", 12'o0000, 1'b1, 1'b0);     iot(3'd3, 12'o0000);
        push_exp("clsk_cleared", 12'o0000, 1'b0, 1'b0);  iot(3'd3, 12'o0000);
        push_exp("stop", 12'o0000, 1'b0, 1'b0);          iot(3'd4, 12'o0000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = nm_q.pop_front(); n_chk++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no observation, need bus=%o", nm, e.bus); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL %s: got bus=%o skip=%b int=%b, need bus=%o skip=%b int=%b", nm, o.bus, o.skp, o.intr, e.bus, e.skp, e.intr); end
            end
        end
    endtask

    task automatic test_preset_interrupt();
        push_exp("clcl", 12'o0000, 1'b0, 1'b0);          iot(3'd7, 12'o0000);
        push_exp("clpr", 12'o0000, 1'b0, 1'b0);          iot(3'd6, 12'o7770);
        run_to_overflow_and_stop("pre");
        push_exp("reload", PRE, 1'b0, 1'b0);             iot(3'd5, 12'o0000);
        push_exp("clsk1", 12'o0000, 1'b1, 1'b0);         iot(3'd3, 12'o0000);
        push_exp("clie", 12'o0000, 1'b0, 1'b0);          iot(3'd1, 12'o0000);
        push_exp("cllr7c", 12'o0000, 1'b0, 1'b0);        iot(3'd4, 12'o0007);
        repeat (8) step();
        push_exp("ovf8", HAS_PRE ? 12'o7770 : 12'o0010, 1'b0, HAS_PRE);  iot(3'd5, 12'o0000);
        push_exp("clsk8", 12'o0000, HAS_PRE, HAS_PRE);  iot(3'd3, 12'o0000);
        push_exp("int_drop", 12'o0000, 1'b0, 1'b0);      look();
        push_exp("stop2", 12'o0000, 1'b0, 1'b0);         iot(3'd4, 12'o0000);
        push_exp("clid", 12'o0000, 1'b0, 1'b0);          iot(3'd2, 12'o0000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = nm_q.pop_front(); n_chk++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no observation, need bus=%o", nm, e.bus); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL %s: got bus=%o skip=%b int=%b, need bus=%o skip=%b int=%b", nm, o.bus, o.skp, o.intr, e.bus, e.skp, e.intr); end
            end
        end
    endtask

    task automatic test_rate1();
        push_exp("clcl_r1", 12'o0000, 1'b0, 1'b0);       iot(3'd7, 12'o0000);
        push_exp("cllr1", 12'o0000, 1'b0, 1'b0);         iot(3'd4, 12'o0001);
        repeat (2999) step();
        push_exp("r1_cnt2", 12'o0002, 1'b0, 1'b0);       iot(3'd5, 12'o0000);
        push_exp("r1_cnt3", 12'o0003, 1'b0, 1'b0);       iot(3'd5, 12'o0000);
        push_exp("r1_bus_idle", 12'o0000, 1'b0, 1'b0);   look();
        push_exp("stop_r1", 12'o0000, 1'b0, 1'b0);       iot(3'd4, 12'o0000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = nm_q.pop_front(); n_chk++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no observation, need bus=%o", nm, e.bus); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL %s: got bus=%o skip=%b int=%b, need bus=%o skip=%b int=%b", nm, o.bus, o.skp, o.intr, e.bus, e.skp, e.intr); end
            end
        end
    endtask

    task automatic test_back_to_back();
        push_exp("clcl_c", 12'o0000, 1'b0, 1'b0);        iot(3'd7, 12'o0000);
        push_exp("cllr7d", 12'o0000, 1'b0, 1'b0);        iot(3'd4, 12'o0007);
        repeat (4095) step();
        push_exp("clsk_on_ovf", 12'o0000, 1'b0, 1'b0);   iot(3'd3, 12'o0000);
        push_exp("stop_c", 12'o0000, 1'b0, 1'b0);        iot(3'd4, 12'o0000);
        push_exp("flag_kept", 12'o0000, 1'b1, 1'b0);     iot(3'd3, 12'o0000);
        push_exp("cllr7e", 12'o0000, 1'b0, 1'b0);        iot(3'd4, 12'o0007);
        repeat (5) step();
        push_exp("clcl_tick", 12'o0000, 1'b0, 1'b0);     iot(3'd7, 12'o0000);
        push_exp("clcl_wins", 12'o0000, 1'b0, 1'b0);     iot(3'd5, 12'o0000);
        push_exp("clcl_c2", 12'o0000, 1'b0, 1'b0);       iot(3'd7, 12'o0000);
        repeat (4095) step();
        push_exp("clcl_on_ovf", 12'o0000, 1'b0, 1'b0);   iot(3'd7, 12'o0000);
        push_exp("stop_c2", 12'o0000, 1'b0, 1'b0);       iot(3'd4, 12'o0000);
        push_exp("clcl_ovf_cnt", 12'o0001, 1'b0, 1'b0);  iot(3'd5, 12'o0000);
        push_exp("clcl_ovf_flag", 12'o0000, 1'b1, 1'b0); iot(3'd3, 12'o0000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = nm_q.pop_front(); n_chk++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no observation, need bus=%o", nm, e.bus); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL %s: got bus=%o skip=%b int=%b, need bus=%o skip=%b int=%b", nm, o.bus, o.skp, o.intr, e.bus, e.skp, e.intr); end
            end
        end
    endtask

    task automatic test_uf_clear();
        push_exp("clcl_u", 12'o0000, 1'b0, 1'b0);        iot(3'd7, 12'o0000);
        run_to_overflow_and_stop("uf");
        UF = 1'b1;
        push_exp("uf_clie", 12'o0000, 1'b0, 1'b0);       iot(3'd1, 12'o0000);
        push_exp("uf_clrd", 12'o0000, 1'b0, 1'b0);       iot(3'd5, 12'o0000);
        push_exp("uf_noint", 12'o0000, 1'b0, 1'b0);      look();
        UF = 1'b0;
        push_exp("clie_u", 12'o0000, 1'b0, 1'b0);        iot(3'd1, 12'o0000);
        push_exp("int_on", 12'o0000, 1'b0, 1'b1);        look();
        push_exp("cllr7g", 12'o0000, 1'b0, 1'b1);        iot(3'd4, 12'o0007);
        repeat (10) step();
        clear = 1'b1;
        push_exp("clear_cyc", 12'o0000, 1'b0, 1'b1);     look();
        clear = 1'b0;
        push_exp("clear_int", 12'o0000, 1'b0, 1'b0);     look();
        repeat (5) step();
        push_exp("clear_cnt", 12'o0000, 1'b0, 1'b0);     iot(3'd5, 12'o0000);
        run_to_overflow_and_stop("kept");
        push_exp("preset_kept", PRE, 1'b0, 1'b0);        iot(3'd5, 12'o0000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = nm_q.pop_front(); n_chk++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no observation, need bus=%o", nm, e.bus); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL %s: got bus=%o skip=%b int=%b, need bus=%o skip=%b int=%b", nm, o.bus, o.skp, o.intr, e.bus, e.skp, e.intr); end
            end
        end
    endtask

    task automatic test_async_reset();
        push_exp("clie_a", 12'o0000, 1'b0, 1'b0);        iot(3'd1, 12'o0000);
        push_exp("int_a", 12'o0000, 1'b0, 1'b1);         look();
        #2 resetn = 1'b0;
        #1 push_exp("async_rst", 12'o0000, 1'b0, 1'b0);
        capture();
        @(negedge clk);
        resetn = 1'b1;
        step();
        push_exp("rst_clrd2", 12'o0000, 1'b0, 1'b0);     iot(3'd5, 12'o0000);
        push_exp("rst_clsk2", 12'o0000, 1'b0, 1'b0);     iot(3'd3, 12'o0000);
        run_to_overflow_and_stop("rst");
        push_exp("preset_reset", 12'o0000, 1'b0, 1'b0);  iot(3'd5, 12'o0000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = nm_q.pop_front(); n_chk++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no observation, need bus=%o", nm, e.bus); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL %s: got bus=%o skip=%b int=%b, need bus=%o skip=%b int=%b", nm, o.bus, o.skp, o.intr, e.bus, e.skp, e.intr); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_preset_interrupt();
        test_rate1();
        test_back_to_back();
        test_uf_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
